// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register unit beside the mMips ALU (multu capture, signed/unsigned div, mthi/mtlo).
// Latency: captures and moves land on the accepting edge; division writes HI/LO 34 cycles after start; divide-by-zero in 1.
// Backpressure: o_busy is high while dividing, and every op presented while o_busy=1 is dropped.
//
// Ports:
//   i_clk, i_rst         rising-edge clock, synchronous active-high reset
//   i_op [2:0]           0 none, 1 capture product, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 ignored
//   i_a, i_b [31:0]      dividend / mthi-mtlo source, divisor
//   i_alu_lo, i_alu_hi   ALU product low / high word
//   o_hi, o_lo [31:0]    HI and LO registers
//   o_busy               division in progress (stall the pipeline)
//   o_done               one-cycle pulse when a division result is written
//
// Optional build macro HILO_DIV_EARLY_OUT_EN: a division whose dividend magnitude is below the
// divisor magnitude skips the iteration phase and goes straight to the sign fix-up cycle.
module hilo_muldiv #(
  parameter int DIV_STEPS = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_alu_lo,
  input  logic [31:0] i_alu_hi,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_DIV  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam int CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_SIGN} state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [31:0]   r_hi, r_lo;
  logic          r_done;
  logic [31:0]   r_quo;      // dividend shifts out of the top while quotient bits shift in at the bottom
  logic [31:0]   r_rem;
  logic [31:0]   r_dsr;
  logic [CW-1:0] r_cnt;
  logic          r_signed, r_qneg, r_rneg;

  logic          w_div_op, w_signed, w_b_zero, w_early, w_last, w_qbit;
  logic [31:0]   w_a_mag, w_b_mag, w_rem_nx, w_q_fix, w_r_fix;
  logic [32:0]   w_sub;

  assign w_div_op = (i_op == OP_DIV) || (i_op == OP_DIVU);
  assign w_signed = (i_op == OP_DIV);
  assign w_b_zero = (i_b == 32'd0);
  assign w_a_mag  = (w_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
  assign w_b_mag  = (w_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;

`ifdef HILO_DIV_EARLY_OUT_EN
  assign w_early = (w_a_mag < w_b_mag);
`else
  assign w_early = 1'b0;
`endif

  // The shifted partial remainder needs 33 bits: rem < divisor can reach 2^32-2, doubled plus one.
  assign w_sub    = {r_rem, r_quo[31]} - {1'b0, r_dsr};
  assign w_qbit   = ~w_sub[32];
  assign w_rem_nx = w_qbit ? w_sub[31:0] : {r_rem[30:0], r_quo[31]};
  assign w_last   = (r_cnt == CW'(DIV_STEPS - 1));

  // -2^31 / -1 needs no special case: the magnitude quotient is 2^31 and both signs cancel.
  assign w_q_fix  = (r_signed && r_qneg) ? (~r_quo + 32'd1) : r_quo;
  assign w_r_fix  = (r_signed && r_rneg) ? (~r_rem + 32'd1) : r_rem;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_div_op && !w_b_zero) w_state_nx = w_early ? S_SIGN : S_DIV;
      S_DIV:  if (w_last) w_state_nx = S_SIGN;
      S_SIGN: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dsr    <= '0;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          case (i_op)
            OP_MUL: begin
              r_lo <= i_alu_lo;
              r_hi <= i_alu_hi;
            end
            OP_MTHI: r_hi <= i_a;
            OP_MTLO: r_lo <= i_a;
            OP_DIV, OP_DIVU: begin
              if (w_b_zero) begin
                r_hi   <= i_a;
                r_lo   <= 32'hFFFF_FFFF;
                r_done <= 1'b1;
              end else begin
                r_quo    <= w_early ? 32'd0 : w_a_mag;
                r_rem    <= w_early ? w_a_mag : 32'd0;
                r_dsr    <= w_b_mag;
                r_cnt    <= '0;
                r_signed <= w_signed;
                r_qneg   <= i_a[31] ^ i_b[31];
                r_rneg   <= i_a[31];
              end
            end
            default: ;
          endcase
        end
        S_DIV: begin
          r_quo <= {r_quo[30:0], w_qbit};
          r_rem <= w_rem_nx;
          r_cnt <= r_cnt + CW'(1);
        end
        S_SIGN: begin
          r_lo   <= w_q_fix;
          r_hi   <= w_r_fix;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_done = r_done;
  assign o_busy = (r_state != S_IDLE);

endmodule
